slice_frac_cfg: RTL and testbench
=================================

Name: slice_frac_cfg

Overview:
- Parametrised fracturable logic slice for the CLB: NUM_LUTS K-input LUTs, each optionally fractured into two (K-1)-input halves.
- Includes a ripple carry chain, an F7/F8-style inter-LUT mux tree and output registers.
- Configuration is loaded on-chip through a serial daisy-chain with a load-tracking FSM, on the user clock.
- Successor to the fixed 4-LUT carry slice: configurable width, self-contained config loading, and a working mux tree.

Parameters:
NUM_LUTS, 4, LUT count; power of 2, >=2
K, 4, inputs per LUT; >=2
CFG_BITS, NUM_LUTS*(2**K+1)+2, derived; total config bits (70 at defaults)

Ports:
clk  in  1  sole clock; all state updates on posedge
rst  in  1  synchronous active-high reset
cfg_en  in  1  shift one config bit this cycle
cfg_in  in  1  serial config data
cfg_out  out  1  serial config data to next slice
cfg_done  out  1  slice fully configured (state READY)
lut_in  in  NUM_LUTS*K  LUT i address = lut_in[i*K +: K]
mux_sel  in  NUM_LUTS-1  mux tree selects
ci  in  1  carry in
reg_ce  in  1  output register enable
o6  out  NUM_LUTS  main/upper LUT outputs
o5  out  NUM_LUTS  lower-half LUT outputs
sum  out  NUM_LUTS  carry-chain sums
co  out  1  carry out
mux_out  out  NUM_LUTS-1  mux tree node outputs
sync_out  out  NUM_LUTS  registered outputs

Behaviour:
- Config register cfg[CFG_BITS-1:0]:
  - When cfg_en=1: cfg <= {cfg_in, cfg[CFG_BITS-1:1]}.
  - cfg_out = cfg[0], ungated.
  - After CFG_BITS shifts, the first bit shifted in sits in cfg[0].
- Bit map:
  - LUT i truth table tt_i = cfg[i*(2**K+1) +: 2**K].
  - frac_i = cfg[i*(2**K+1)+2**K].
  - use_cc = cfg[CFG_BITS-2].
  - reg_mode = cfg[CFG_BITS-1].
- FSM with counter cnt (width clog2(CFG_BITS+1)); states UNCFG, LOADING, READY:
  - UNCFG, cfg_en=1: -> LOADING, cnt=1.
  - LOADING, cfg_en=1: cnt+1; if cnt==CFG_BITS-1, -> READY, cnt=0.
  - LOADING, cfg_en=0: hold state and cnt; pauses are allowed.
  - READY, cfg_en=1: -> LOADING, cnt=1 (reload). The bit still shifts.
  - cfg_done = (state==READY), registered. It rises in the cycle after the CFG_BITS-th cfg_en edge.
- rst (highest priority): cfg=0, state=UNCFG, cnt=0, sync_out=0.
- LUT i, with addr a = K-bit address and lo = a[K-2:0]:
  - o5_i = tt_i[lo].
  - o6_i = frac_i ? tt_i[2**(K-1)+lo] : tt_i[a].
- Carry chain (use_cc=1):
  - p_i = o6_i, g_i = o5_i.
  - c_0 = ci; c_{i+1} = p_i ? c_i : g_i.
  - sum_i = p_i ^ c_i; co = c_NUM_LUTS.
  - With use_cc=0: sum=0, co=0.
- Mux tree, heap-numbered:
  - Leaves n = NUM_LUTS..2*NUM_LUTS-1 carry o6[n-NUM_LUTS].
  - Node n (1..NUM_LUTS-1) = mux_sel[n-1] ? v[2n+1] : v[2n].
  - mux_out[n-1] = node n. All combinational.
- Output gating: while state!=READY, o5, o6, sum, co and mux_out are forced to 0.
- Output registers: sync_out[i] updates only when state==READY and reg_ce=1.
  - Captures o6_i if reg_mode=0, else sum_i.
  - Otherwise holds, including throughout LOADING.
- Latency: combinational outputs follow inputs in 0 cycles. sync_out updates 1 cycle after.
- Simultaneous events:
  - rst together with cfg_en: reset wins; no shift occurs.
  - cfg_en in READY: the same cycle's reg_ce capture still occurs, because state is still READY at that edge.

Test Plan:
- Reset: assert rst 2 cycles, with cfg_en=1 and cfg_in=1 held -> cfg_done=0, cfg_out=0, sync_out=0, all combinational outputs 0.
- Load count: shift 70 bits -> cfg_done=0 after 69 edges, 1 after 70. Insert a 5-cycle cfg_en=0 gap mid-load -> cfg_done is delayed by exactly 5 cycles. On reload, cfg_out replays the first-loaded bits in order.
- Adder: all frac=1, tt=0x6688, use_cc=1, addr[0]=a_i, addr[1]=b_i, addr[3:2]=0; a=0xB, b=0x6, ci=1 -> sum=0x2, co=1. With reg_mode=1 and reg_ce=1, sync_out=0x2 next cycle.
- Mux tree: frac=0, tt3=0xFFFF, others 0 -> o6=4'b1000. mux_sel=3'b101 -> mux_out=3'b101. mux_sel=3'b100 -> mux_out=3'b100.
- Reload mid-operation: from READY with sync_out=0x2, assert cfg_en -> cfg_done=0 next cycle, o6/sum/co=0, sync_out holds 0x2 despite reg_ce=1.
- Reset mid-load: rst after 40 bits -> UNCFG. A fresh 70-bit load is then required before cfg_done=1.

Source files
------------

// File: rtl/slice_frac_cfg.sv
// Fracturable K-input LUT slice with ripple carry, a heap-ordered mux tree and output registers.
// Configuration is shifted in serially and daisy-chains out of cfg_out to the next slice.
//
// state   | meaning
// UNCFG   | no config bit shifted since reset
// LOADING | shifting in; cnt holds the number of bits received so far
// READY   | full frame received, datapath outputs enabled
module slice_frac_cfg #(
    parameter int NUM_LUTS = 4,
    parameter int K        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_en,
    input  logic                  cfg_in,
    output logic                  cfg_out,
    output logic                  cfg_done,
    input  logic [NUM_LUTS*K-1:0] lut_in,
    input  logic [NUM_LUTS-2:0]   mux_sel,
    input  logic                  ci,
    input  logic                  reg_ce,
    output logic [NUM_LUTS-1:0]   o6,
    output logic [NUM_LUTS-1:0]   o5,
    output logic [NUM_LUTS-1:0]   sum,
    output logic                  co,
    output logic [NUM_LUTS-2:0]   mux_out,
    output logic [NUM_LUTS-1:0]   sync_out
);

    localparam int TT_BITS    = 2**K;
    localparam int LUT_STRIDE = TT_BITS + 1;
    localparam int CFG_BITS   = NUM_LUTS*LUT_STRIDE + 2;
    localparam int CNT_W      = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {
        UNCFG,
        LOADING,
        READY
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CFG_BITS-1:0] cfg;

    logic               use_cc;
    logic               reg_mode;
    logic               ready;
    logic [NUM_LUTS-1:0] o6_raw, o5_raw, sum_raw;
    logic               co_raw;
    logic [NUM_LUTS-2:0] mux_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg <= '0;
        end else if (cfg_en) begin
            cfg <= {cfg_in, cfg[CFG_BITS-1:1]};
        end
    end

    assign cfg_out  = cfg[0];
    assign use_cc   = cfg[CFG_BITS-2];
    assign reg_mode = cfg[CFG_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNCFG;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            UNCFG: begin
                if (cfg_en) begin
                    state_nx = LOADING;
                    cnt_nx   = CNT_W'(1);
                end
            end
            LOADING: begin
                if (cfg_en) begin
                    if (cnt == CNT_W'(CFG_BITS - 1)) begin
                        state_nx = READY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            READY: begin
                // any new bit starts a fresh frame; the old config is being pushed out
                if (cfg_en) begin
                    state_nx = LOADING;
                    cnt_nx   = CNT_W'(1);
                end
            end
            default: begin
                state_nx = UNCFG;
                cnt_nx   = '0;
            end
        endcase
    end

    assign ready    = (state == READY);
    assign cfg_done = ready;

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic [TT_BITS-1:0] tt;
        logic               frac;
        logic [K-1:0]       a;
        logic [K-2:0]       lo;

        assign tt   = cfg[i*LUT_STRIDE +: TT_BITS];
        assign frac = cfg[i*LUT_STRIDE + TT_BITS];
        assign a    = lut_in[i*K +: K];
        assign lo   = a[K-2:0];

        // fractured: o6 reads the upper half, o5 always reads the lower half
        assign o5_raw[i] = tt[{1'b0, lo}];
        assign o6_raw[i] = frac ? tt[{1'b1, lo}] : tt[a];
    end

    always_comb begin
        logic [NUM_LUTS:0] c;
        c       = '0;
        sum_raw = '0;
        c[0]    = ci;
        for (int i = 0; i < NUM_LUTS; i++) begin
            c[i+1]     = o6_raw[i] ? c[i] : o5_raw[i];
            sum_raw[i] = o6_raw[i] ^ c[i];
        end
        co_raw = c[NUM_LUTS];
    end

    always_comb begin
        logic [2*NUM_LUTS-1:1] v;
        v = '0;
        for (int n = NUM_LUTS; n < 2*NUM_LUTS; n++) begin
            v[n] = o6_raw[n-NUM_LUTS];
        end
        for (int n = NUM_LUTS-1; n >= 1; n--) begin
            v[n] = mux_sel[n-1] ? v[2*n+1] : v[2*n];
        end
        mux_raw = v[NUM_LUTS-1:1];
    end

    assign o6      = ready ? o6_raw : '0;
    assign o5      = ready ? o5_raw : '0;
    assign sum     = (ready && use_cc) ? sum_raw : '0;
    assign co      = ready && use_cc && co_raw;
    assign mux_out = ready ? mux_raw : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_out <= '0;
        end else if (ready && reg_ce) begin
            sync_out <= reg_mode ? sum : o6;
        end
    end

endmodule

// File: tb/tb_slice_frac_cfg.sv
// Directed bench for slice_frac_cfg at default parameters (4 LUTs, K=4, 70 config bits).
module tb_slice_frac_cfg;

    localparam int NL = 4;
    localparam int KK = 4;
    localparam int CB = 70;

    logic           clk = 1'b0;
    logic           rst, cfg_en, cfg_in, cfg_out, cfg_done, ci, reg_ce, co;
    logic [NL*KK-1:0] lut_in;
    logic [NL-2:0]  mux_sel, mux_out;
    logic [NL-1:0]  o6, o5, sum, sync_out;

    int checks = 0;
    int errors = 0;
    logic [CB-1:0] rep;
    logic [CB-1:0] w_add, w_mux;

    slice_frac_cfg #(.NUM_LUTS(NL), .K(KK)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
        .cfg_done(cfg_done), .lut_in(lut_in), .mux_sel(mux_sel), .ci(ci), .reg_ce(reg_ce),
        .o6(o6), .o5(o5), .sum(sum), .co(co), .mux_out(mux_out), .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] lut_in;
        logic        ci;
        logic [2:0]  sel;
        logic [3:0]  o6;
        logic [3:0]  o5;
        logic [3:0]  sum;
        logic        co;
        logic [2:0]  mo;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CB-1:0] mk(input logic [NL*16-1:0] tts, input logic [NL-1:0] frac,
                                         input logic use_cc, input logic reg_mode);
        logic [CB-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) begin
            w[i*17 +: 16] = tts[i*16 +: 16];
            w[i*17 + 16]  = frac[i];
        end
        w[CB-2] = use_cc;
        w[CB-1] = reg_mode;
        return w;
    endfunction

    // shifts bits start..CB-1, optional pause before bit gap_at; checks cfg_done timing
    task automatic load(input logic [CB-1:0] w, input int start, input int gap_at, input int gap_len,
                        input string tag);
        for (int j = start; j < CB; j++) begin
            if (j == gap_at) begin
                cfg_en = 1'b0;
                repeat (gap_len) tick();
                chk({tag, "_done_in_gap"}, cfg_done, 1'b0);
            end
            cfg_en = 1'b1;
            cfg_in = w[j];
            rep[j] = cfg_out;
            if (j == CB-1) chk({tag, "_done_before_last"}, cfg_done, 1'b0);
            tick();
        end
        cfg_en = 1'b0;
        chk({tag, "_done_after_last"}, cfg_done, 1'b1);
    endtask

    initial begin
        tbl[0] = '{16'h1231, 1'b1, 3'b000, 4'hD, 4'h2, 4'h2, 1'b1, 3'b111};
        tbl[1] = '{16'h0000, 1'b0, 3'b111, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000};
        tbl[2] = '{16'h1111, 1'b1, 3'b010, 4'hF, 4'h0, 4'h0, 1'b1, 3'b111};
        tbl[3] = '{16'h0123, 1'b0, 3'b001, 4'h6, 4'h1, 4'h8, 1'b0, 3'b101};
        tbl[4] = '{16'h3333, 1'b0, 3'b111, 4'h0, 4'hF, 4'hE, 1'b1, 3'b000};
        tbl[5] = '{16'h9AB9, 1'b1, 3'b000, 4'hD, 4'h2, 4'h2, 1'b1, 3'b111};

        w_add = mk({4{16'h6688}}, 4'hF, 1'b1, 1'b1);
        w_mux = mk({16'hFFFF, 16'h0000, 16'h0000, 16'h0000}, 4'h0, 1'b0, 1'b0);

        // reset with shifting requested: reset must win
        rst = 1'b1; cfg_en = 1'b1; cfg_in = 1'b1;
        lut_in = '1; mux_sel = '1; ci = 1'b1; reg_ce = 1'b1;
        repeat (2) tick();
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_cfg_out", cfg_out, 1'b0);
        chk("rst_sync", sync_out, 4'h0);
        chk("rst_o6", o6, 4'h0);
        chk("rst_o5", o5, 4'h0);
        chk("rst_sum", sum, 4'h0);
        chk("rst_co", co, 1'b0);
        chk("rst_mux", mux_out, 3'b000);
        rst = 1'b0; cfg_en = 1'b0; reg_ce = 1'b0;
        tick();
        chk("rst_release_done", cfg_done, 1'b0);

        load(w_add, 0, -1, 0, "add_load");

        for (int t = 0; t < 6; t++) begin
            lut_in  = tbl[t].lut_in;
            ci      = tbl[t].ci;
            mux_sel = tbl[t].sel;
            #1;
            chk($sformatf("vec%0d_o6", t), o6, tbl[t].o6);
            chk($sformatf("vec%0d_o5", t), o5, tbl[t].o5);
            chk($sformatf("vec%0d_sum", t), sum, tbl[t].sum);
            chk($sformatf("vec%0d_co", t), co, tbl[t].co);
            chk($sformatf("vec%0d_mux", t), mux_out, tbl[t].mo);
            tick();
        end
        chk("sync_hold_no_ce", sync_out, 4'h0);

        lut_in = tbl[0].lut_in; ci = 1'b1; reg_ce = 1'b1;
        tick();
        chk("sync_sum_capture", sync_out, 4'h2);

        // reload from READY: first shift done by hand, rest via load with a 5-cycle pause
        rep[0] = cfg_out;
        cfg_en = 1'b1; cfg_in = w_mux[0];
        tick();
        chk("reload_done", cfg_done, 1'b0);
        chk("reload_o6", o6, 4'h0);
        chk("reload_sum", sum, 4'h0);
        chk("reload_co", co, 1'b0);
        chk("reload_sync", sync_out, 4'h2);
        lut_in = tbl[3].lut_in; ci = 1'b0;
        load(w_mux, 1, 35, 5, "mux_load");
        reg_ce = 1'b0;
        chk("loading_sync_hold", sync_out, 4'h2);
        chk("reload_replay", rep, w_add);

        mux_sel = 3'b101;
        #1;
        chk("mux_o6", o6, 4'h8);
        chk("mux_o5", o5, 4'h8);
        chk("mux_nocc_sum", sum, 4'h0);
        chk("mux_nocc_co", co, 1'b0);
        chk("mux_sel101", mux_out, 3'b101);
        mux_sel = 3'b100;
        #1;
        chk("mux_sel100", mux_out, 3'b100);
        reg_ce = 1'b1;
        tick();
        reg_ce = 1'b0;
        chk("sync_o6_capture", sync_out, 4'h8);

        // reset in the middle of a load discards progress
        for (int j = 0; j < 40; j++) begin
            cfg_en = 1'b1; cfg_in = w_add[j];
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; cfg_en = 1'b0;
        chk("midrst_done", cfg_done, 1'b0);
        chk("midrst_sync", sync_out, 4'h0);
        chk("midrst_cfg_out", cfg_out, 1'b0);
        tick();
        load(w_add, 0, -1, 0, "fresh_load");
        lut_in = tbl[0].lut_in; ci = 1'b1; mux_sel = 3'b000;
        #1;
        chk("fresh_sum", sum, 4'h2);
        chk("fresh_co", co, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
